pipe_ctrl_unit: RTL and testbench

Sequential pipelined successor to the combinational MIPS control decoder. It decodes the instruction in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB control registers. It also owns the load-use and branch-operand interlocks, branch/jump flush, and a whole-pipeline freeze on a data-memory busy handshake. It sits beside the datapath and drives all stage muxes and enables.

---
 rtl/pipe_ctrl_pkg.sv | 38 +++
 rtl/pipe_ctrl_unit_decoder.sv | 67 ++++++
 rtl/pipe_ctrl_unit.sv | 108 ++++++++++
 tb/tb_pipe_ctrl_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and the control bundle carried down the pipeline control registers.
package pipe_ctrl_pkg;

    localparam int unsigned OPC_WIDTH  = 6;
    localparam int unsigned FUNC_WIDTH = 6;
    localparam int unsigned REG_WIDTH  = 5;
    localparam int unsigned PCS_WIDTH  = 2;

    localparam logic [OPC_WIDTH-1:0] OP_LW    = 6'b100011;
    localparam logic [OPC_WIDTH-1:0] OP_SW    = 6'b101011;
    localparam logic [OPC_WIDTH-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPC_WIDTH-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPC_WIDTH-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPC_WIDTH-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPC_WIDTH-1:0] OP_J     = 6'b000010;
    localparam logic [OPC_WIDTH-1:0] OP_NOP   = 6'b000001;

    localparam logic [FUNC_WIDTH-1:0] ADDF = 6'b100000;
    localparam logic [FUNC_WIDTH-1:0] NOPF = 6'b000000;

    localparam logic [PCS_WIDTH-1:0] PC_SEQ = 2'b00;
    localparam logic [PCS_WIDTH-1:0] PC_BR  = 2'b01;
    localparam logic [PCS_WIDTH-1:0] PC_JMP = 2'b10;

    typedef struct packed {
        logic                  alu_src;
        logic                  reg_dst;
        logic [FUNC_WIDTH-1:0] func;
        logic                  mem_read;
        logic                  mem_write;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic [REG_WIDTH-1:0]  dst;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_unit_decoder.sv
// Combinational ID-stage decode: opcode to control bundle, source-use flags and illegal flag.
module ctrl_decoder
    import pipe_ctrl_pkg::*;
(
    input  logic [OPC_WIDTH-1:0]  opcode,
    input  logic [FUNC_WIDTH-1:0] func_in,
    input  logic [REG_WIDTH-1:0]  rt,
    input  logic [REG_WIDTH-1:0]  rd,
    output ctrl_bundle_t          bundle,
    output logic                  uses_rs,
    output logic                  uses_rt,
    output logic                  illegal
);

    always_comb begin
        bundle  = BUBBLE;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_LW: begin
                bundle.alu_src    = 1'b1;
                bundle.mem_read   = 1'b1;
                bundle.reg_write  = 1'b1;
                bundle.mem_to_reg = 1'b1;
                bundle.func       = ADDF;
                uses_rs           = 1'b1;
            end
            OP_SW: begin
                bundle.alu_src   = 1'b1;
                bundle.mem_write = 1'b1;
                bundle.func      = ADDF;
                uses_rs          = 1'b1;
                uses_rt          = 1'b1;
            end
            OP_ADDI: begin
                bundle.alu_src   = 1'b1;
                bundle.reg_write = 1'b1;
                bundle.func      = ADDF;
                uses_rs          = 1'b1;
            end
            OP_RTYPE: begin
                bundle.reg_dst   = 1'b1;
                bundle.reg_write = 1'b1;
                bundle.func      = func_in;
                uses_rs          = 1'b1;
                uses_rt          = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
            end
            OP_J, OP_NOP: ;
            default: illegal = 1'b1;
        endcase

        // Loads keep mem_read even when targeting r0 so the access still happens.
        if (bundle.reg_write) begin
            bundle.dst = bundle.reg_dst ? rd : rt;
            if (bundle.dst == '0)
                bundle.reg_write = 1'b0;
        end else if (bundle.mem_read) begin
            bundle.dst = rt;
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control: ID decode, ID/EX..MEM/WB control registers, interlocks, redirect and freeze.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_W     = 5,
    parameter int unsigned FUNC_W    = 6,
    parameter bit          HAZARD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        opcode,
    input  logic [FUNC_W-1:0] func_in,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              eq_regs,
    input  logic              mem_busy,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic [1:0]        pc_src,
    output logic              illegal,
    output logic              ex_alu_src,
    output logic [FUNC_W-1:0] ex_func,
    output logic [REG_W-1:0]  ex_dst,
    output logic              mem_read,
    output logic              mem_write,
    output logic [REG_W-1:0]  mem_dst,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [REG_W-1:0]  wb_dst
);

    ctrl_bundle_t         dec, id_ex, ex_mem, mem_wb;
    logic                 uses_rs, uses_rt;
    logic [REG_WIDTH-1:0] rs, rt;
    logic                 is_branch, is_jump, taken;
    logic                 ex_hit, mem_hit, load_use, br_hazard, stall;

    assign rs = REG_WIDTH'(id_rs);
    assign rt = REG_WIDTH'(id_rt);

    ctrl_decoder u_dec (
        .opcode  (OPC_WIDTH'(opcode)),
        .func_in (FUNC_WIDTH'(func_in)),
        .rt      (rt),
        .rd      (REG_WIDTH'(id_rd)),
        .bundle  (dec),
        .uses_rs (uses_rs),
        .uses_rt (uses_rt),
        .illegal (illegal)
    );

    assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign is_jump   = (opcode == OP_J);
    assign taken     = ((opcode == OP_BEQ) && eq_regs) || ((opcode == OP_BNE) && !eq_regs);

    // Interlock detection; branches compare in ID so they need operands one stage earlier.
    assign load_use  = id_ex.mem_read && (id_ex.dst != '0) &&
                       ((uses_rs && (id_ex.dst == rs)) || (uses_rt && (id_ex.dst == rt)));
    assign ex_hit    = id_ex.reg_write && ((id_ex.dst == rs) || (id_ex.dst == rt));
    assign mem_hit   = ex_mem.mem_read && (ex_mem.dst != '0) &&
                       ((ex_mem.dst == rs) || (ex_mem.dst == rt));
    assign br_hazard = is_branch && (ex_hit || mem_hit);
    assign stall     = HAZARD_EN && (load_use || br_hazard);

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex  <= BUBBLE;
            ex_mem <= BUBBLE;
            mem_wb <= BUBBLE;
        end else if (!mem_busy) begin
            id_ex  <= stall ? BUBBLE : dec;
            ex_mem <= id_ex;
            mem_wb <= ex_mem;
        end
    end

    // Front-end steering: rst > freeze > stall > redirect > advance.
    always_comb begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b0;
        pc_src      = PC_SEQ;
        if (!rst && !mem_busy && !stall) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if (is_jump) begin
                pc_src      = PC_JMP;
                if_id_flush = 1'b1;
            end else if (taken) begin
                pc_src      = PC_BR;
                if_id_flush = 1'b1;
            end
        end
    end

    assign ex_alu_src    = id_ex.alu_src;
    assign ex_func       = FUNC_W'(id_ex.func);
    assign ex_dst        = REG_W'(id_ex.dst);
    assign mem_read      = ex_mem.mem_read;
    assign mem_write     = ex_mem.mem_write;
    assign mem_dst       = REG_W'(ex_mem.dst);
    assign wb_reg_write  = mem_wb.reg_write;
    assign wb_mem_to_reg = mem_wb.mem_to_reg;
    assign wb_dst        = REG_W'(mem_wb.dst);

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: interlocks, redirect, freeze, reset and decode corner cases.
module tb_pipe_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'b000001;
    logic [5:0] func_in = 6'b0;
    logic [4:0] id_rs = 5'd0, id_rt = 5'd0, id_rd = 5'd0;
    logic       eq_regs = 1'b0, mem_busy = 1'b0;
    logic       pc_write, if_id_write, if_id_flush, illegal;
    logic [1:0] pc_src;
    logic       ex_alu_src, mem_read, mem_write, wb_reg_write, wb_mem_to_reg;
    logic [5:0] ex_func;
    logic [4:0] ex_dst, mem_dst, wb_dst;

    int tests = 0;
    int fails = 0;

    localparam logic [5:0] LW = 6'b100011, RT = 6'b000000, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, J = 6'b000010, NOP = 6'b000001;

    pipe_ctrl_unit #(.REG_W(5), .FUNC_W(6), .HAZARD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func_in(func_in),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .eq_regs(eq_regs), .mem_busy(mem_busy),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .pc_src(pc_src), .illegal(illegal), .ex_alu_src(ex_alu_src), .ex_func(ex_func),
        .ex_dst(ex_dst), .mem_read(mem_read), .mem_write(mem_write), .mem_dst(mem_dst),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_dst(wb_dst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Applies one ID-stage instruction at the falling edge, then lets outputs settle.
    task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [5:0] f, input logic eq,
                         input logic busy, input logic r);
        @(negedge clk);
        opcode = op; id_rs = rs; id_rt = rt; id_rd = rd; func_in = f;
        eq_regs = eq; mem_busy = busy; rst = r;
        #1;
    endtask

    initial begin
        // Reset state
        drive(NOP, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_pc_write", 32'(pc_write), 0);
        chk("rst_if_id_write", 32'(if_id_write), 0);
        chk("rst_ex_func", 32'(ex_func), 0);
        chk("rst_mem_read", 32'(mem_read), 0);
        chk("rst_wb_reg_write", 32'(wb_reg_write), 0);

        // Load-use: LW r2,(r1) ; ADD r3,r2,r4
        drive(LW, 1, 2, 0, 0, 0, 0, 0);
        chk("lw_pc_write", 32'(pc_write), 1);
        chk("lw_illegal", 32'(illegal), 0);
        drive(RT, 2, 4, 3, 6'h20, 0, 0, 0);
        chk("lu_ex_dst", 32'(ex_dst), 2);
        chk("lu_ex_alu_src", 32'(ex_alu_src), 1);
        chk("lu_stall_pc_write", 32'(pc_write), 0);
        chk("lu_stall_if_id_write", 32'(if_id_write), 0);
        chk("lu_stall_flush", 32'(if_id_flush), 0);
        drive(RT, 2, 4, 3, 6'h20, 0, 0, 0);
        chk("lu_bubble_ex_func", 32'(ex_func), 0);
        chk("lu_bubble_ex_dst", 32'(ex_dst), 0);
        chk("lu_mem_read", 32'(mem_read), 1);
        chk("lu_mem_dst", 32'(mem_dst), 2);
        chk("lu_release_pc_write", 32'(pc_write), 1);
        drive(NOP, 0, 0, 0, 0, 0, 0, 0);
        chk("add_ex_dst", 32'(ex_dst), 3);
        chk("add_ex_func", 32'(ex_func), 32'h20);
        chk("lw_wb_reg_write", 32'(wb_reg_write), 1);
        chk("lw_wb_mem_to_reg", 32'(wb_mem_to_reg), 1);
        chk("lw_wb_dst", 32'(wb_dst), 2);
        drive(NOP, 0, 0, 0, 0, 0, 0, 0);
        chk("add_mem_dst", 32'(mem_dst), 3);
        drive(NOP, 0, 0, 0, 0, 0, 0, 0);
        chk("add_wb_dst", 32'(wb_dst), 3);
        chk("add_wb_mem_to_reg", 32'(wb_mem_to_reg), 0);

        // BEQ taken / next slot / BEQ not taken / J
        drive(BEQ, 6, 7, 0, 0, 1, 0, 0);
        chk("beq_t_pc_src", 32'(pc_src), 1);
        chk("beq_t_flush", 32'(if_id_flush), 1);
        drive(NOP, 0, 0, 0, 0, 0, 0, 0);
        chk("beq_t_once_pc_src", 32'(pc_src), 0);
        chk("beq_t_once_flush", 32'(if_id_flush), 0);
        drive(BEQ, 6, 7, 0, 0, 0, 0, 0);
        chk("beq_nt_pc_src", 32'(pc_src), 0);
        chk("beq_nt_flush", 32'(if_id_flush), 0);
        chk("beq_nt_pc_write", 32'(pc_write), 1);
        drive(J, 0, 0, 0, 0, 0, 0, 0);
        chk("j_pc_src", 32'(pc_src), 2);
        chk("j_flush", 32'(if_id_flush), 1);

        // ADD r5 ; BNE r5,r0 -> one branch-operand stall, then taken
        drive(RT, 1, 4, 5, 6'h20, 0, 0, 0);
        chk("add5_pc_write", 32'(pc_write), 1);
        drive(BNE, 5, 0, 0, 0, 0, 0, 0);
        chk("bne_stall_ex_dst", 32'(ex_dst), 5);
        chk("bne_stall_pc_write", 32'(pc_write), 0);
        chk("bne_stall_pc_src", 32'(pc_src), 0);
        chk("bne_stall_flush", 32'(if_id_flush), 0);
        drive(BNE, 5, 0, 0, 0, 0, 0, 0);
        chk("bne_taken_pc_src", 32'(pc_src), 1);
        chk("bne_taken_flush", 32'(if_id_flush), 1);

        // Freeze with LW r8 in MEM and ADD r9 in WB
        drive(RT, 1, 1, 9, 6'h20, 0, 0, 0);
        drive(LW, 1, 8, 0, 0, 0, 0, 0);
        drive(NOP, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) drive(BEQ, 6, 7, 0, 0, 1, 1, 0);
            else        drive(NOP, 0, 0, 0, 0, 0, 1, 0);
            chk("frz_mem_read", 32'(mem_read), 1);
            chk("frz_mem_dst", 32'(mem_dst), 8);
            chk("frz_wb_reg_write", 32'(wb_reg_write), 1);
            chk("frz_wb_dst", 32'(wb_dst), 9);
            chk("frz_pc_write", 32'(pc_write), 0);
            chk("frz_if_id_write", 32'(if_id_write), 0);
            chk("frz_pc_src", 32'(pc_src), 0);
            chk("frz_flush", 32'(if_id_flush), 0);
        end
        drive(NOP, 0, 0, 0, 0, 0, 0, 0);
        chk("frz_release_pc_write", 32'(pc_write), 1);
        chk("frz_release_mem_dst", 32'(mem_dst), 8);
        drive(LW, 1, 11, 0, 0, 0, 0, 0);
        chk("frz_adv_wb_dst", 32'(wb_dst), 8);
        chk("frz_adv_wb_mem_to_reg", 32'(wb_mem_to_reg), 1);
        chk("frz_adv_mem_read", 32'(mem_read), 0);

        // Reset during load-use stall (LW r11 ; ADD r12,r11,r0)
        drive(RT, 11, 0, 12, 6'h20, 0, 0, 0);
        chk("rs_stall_pc_write", 32'(pc_write), 0);
        drive(RT, 11, 0, 12, 6'h20, 0, 0, 1);
        chk("rs_during_pc_write", 32'(pc_write), 0);
        chk("rs_during_if_id_write", 32'(if_id_write), 0);
        drive(NOP, 0, 0, 0, 0, 0, 0, 1);
        chk("rs_mem_read", 32'(mem_read), 0);
        chk("rs_mem_dst", 32'(mem_dst), 0);
        chk("rs_ex_dst", 32'(ex_dst), 0);
        chk("rs_wb_reg_write", 32'(wb_reg_write), 0);
        drive(RT, 11, 0, 12, 6'h20, 0, 0, 0);
        chk("rs_no_residual_pc_write", 32'(pc_write), 1);
        chk("rs_no_residual_if_id_write", 32'(if_id_write), 1);

        // Illegal opcode, then RTYPE with rd=0
        drive(6'b111111, 1, 2, 3, 0, 0, 0, 0);
        chk("ill_flag", 32'(illegal), 1);
        chk("ill_pc_write", 32'(pc_write), 1);
        drive(RT, 1, 2, 0, 6'h20, 0, 0, 0);
        chk("ill_clear", 32'(illegal), 0);
        chk("ill_bubble_ex_func", 32'(ex_func), 0);
        chk("ill_bubble_ex_dst", 32'(ex_dst), 0);
        drive(NOP, 0, 0, 0, 0, 0, 0, 0);
        chk("r0_ex_func", 32'(ex_func), 32'h20);
        chk("add12_wb_reg_write", 32'(wb_reg_write), 1);
        chk("add12_wb_dst", 32'(wb_dst), 12);
        drive(NOP, 0, 0, 0, 0, 0, 0, 0);
        chk("ill_bubble_wb_reg_write", 32'(wb_reg_write), 0);
        drive(NOP, 0, 0, 0, 0, 0, 0, 0);
        chk("r0_wb_reg_write", 32'(wb_reg_write), 0);
        chk("r0_wb_dst", 32'(wb_dst), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
